// File: rtl/line_burst_adaptor.sv
// ---------------------------------------------------------------------------
// line_burst_adaptor
//
// Memory-side responder for a single cacheline port. A 256-bit line read or
// write from the requester is carried out as a 4-beat, 64-bit burst to
// physical memory. The read line is assembled beat by beat, and the requester
// gets a one-cycle line_resp pulse when the burst completes.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   line_read      line read request, held until line_resp
//   line_write     line write request, held until line_resp
//   line_address   line address (low offset bits ignored)
//   line_wdata     write line; beat i = bits [64i+63:64i]
//   line_rdata     assembled read line; valid while line_resp is high
//   line_resp      one-cycle completion pulse
//   burst_read     memory read burst request
//   burst_write    memory write burst request
//   burst_address  line-aligned burst address
//   burst_wdata    current write beat
//   burst_rdata    current read beat from memory
//   burst_resp     memory beat acknowledge, one per beat
// ---------------------------------------------------------------------------
module line_burst_adaptor #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [31:0]           line_address,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  line_resp,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [31:0]           burst_address,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_resp
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFS_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_next;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic                    accept;

  // Byte-offset bits inside the line never reach memory.
  logic unused_offset_bits;
  assign unused_offset_bits = ^line_address[OFS_W-1:0];

  assign cnt_next = cnt + 1'b1;
  assign accept   = (state == IDLE) && (line_read || line_write);

  // NOTE: wdata_q is a wide data holding register whose contents are only
  // consumed after being loaded on accept, so it carries no reset; leaving
  // it out of the reset network keeps the reset fan-out small.
  always_ff @(posedge clk) begin
    if (accept) begin
      wdata_q <= line_wdata;
    end
  end

  // NOTE: all state and registered outputs are updated with non-blocking
  // assignments so every register samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      line_rdata    <= '0;
      line_resp     <= 1'b0;
      burst_read    <= 1'b0;
      burst_write   <= 1'b0;
      burst_address <= '0;
      burst_wdata   <= '0;
    end else begin
      line_resp <= 1'b0;
      case (state)
        IDLE: begin
          // Read takes priority; a simultaneous write must be re-presented.
          if (line_read) begin
            state         <= READ;
            cnt           <= '0;
            burst_read    <= 1'b1;
            burst_address <= {line_address[31:OFS_W], OFS_W'(0)};
          end else if (line_write) begin
            state         <= WRITE;
            cnt           <= '0;
            burst_write   <= 1'b1;
            burst_address <= {line_address[31:OFS_W], OFS_W'(0)};
            burst_wdata   <= line_wdata[BEAT_WIDTH-1:0];
          end
        end

        READ: begin
          if (burst_resp) begin
            line_rdata[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= burst_rdata;
            cnt <= cnt_next;
            if (cnt == LAST_BEAT) begin
              state         <= DONE;
              line_resp     <= 1'b1;
              burst_read    <= 1'b0;
              burst_address <= '0;
            end
          end
        end

        WRITE: begin
          if (burst_resp) begin
            cnt <= cnt_next;
            if (cnt == LAST_BEAT) begin
              state         <= DONE;
              line_resp     <= 1'b1;
              burst_write   <= 1'b0;
              burst_address <= '0;
              burst_wdata   <= '0;
            end else begin
              // Present the next beat from the frozen copy of the line.
              burst_wdata <= wdata_q[int'(cnt_next)*BEAT_WIDTH +: BEAT_WIDTH];
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// ---------------------------------------------------------------------------
// tb_line_burst_adaptor
//
// Directed bench for line_burst_adaptor. The bench plays both requester and
// memory; every expected value is written out by hand below.
// ---------------------------------------------------------------------------
module tb_line_burst_adaptor;

  logic         clk;
  logic         rst;
  logic         line_read;
  logic         line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int total;
  int bad;

  logic [255:0] exp_line;

  line_burst_adaptor dut (
    .clk           (clk),
    .rst           (rst),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_address  (line_address),
    .line_wdata    (line_wdata),
    .line_rdata    (line_rdata),
    .line_resp     (line_resp),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_address (burst_address),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Outputs that must all be low when no burst is in progress.
  task automatic check_quiet(input string tag);
    check({tag, "_resp"},  256'(line_resp),     256'(0));
    check({tag, "_rd"},    256'(burst_read),    256'(0));
    check({tag, "_wr"},    256'(burst_write),   256'(0));
    check({tag, "_addr"},  256'(burst_address), 256'(0));
    check({tag, "_wdata"}, 256'(burst_wdata),   256'(0));
  endtask

  // One complete line transaction. Called at a negedge; returns at the
  // negedge of the idle cycle after line_resp. 'stall' makes memory answer
  // only on every other cycle; 'perturb' scrambles the line inputs after
  // the first beat has been acknowledged.
  task automatic line_op(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [255:0] wline,
                         input logic [255:0] rline, input bit stall,
                         input bit perturb, input logic exp_rd,
                         input logic [255:0] exp_rdata);
    int beats;
    int cyc;
    logic give;
    line_read    = rd;
    line_write   = wr;
    line_address = addr;
    line_wdata   = wline;
    @(negedge clk);
    beats = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 40) begin
      check({tag, "_bread"},  256'(burst_read),    256'(exp_rd));
      check({tag, "_bwrite"}, 256'(burst_write),   256'(!exp_rd));
      check({tag, "_baddr"},  256'(burst_address), 256'({addr[31:5], 5'b0}));
      check({tag, "_lresp"},  256'(line_resp),     256'(0));
      if (!exp_rd)
        check({tag, "_bwdata"}, 256'(burst_wdata), 256'(wline[beats*64 +: 64]));
      give = stall ? (cyc % 2 == 1) : 1'b1;
      burst_resp  = give;
      burst_rdata = rline[beats*64 +: 64];
      if (give) beats++;
      if (perturb && beats == 1) begin
        line_address = 32'hDEAD_BEEF;
        line_wdata   = ~wline;
      end
      @(negedge clk);
      cyc++;
    end
    if (beats != 4) check({tag, "_timeout"}, 256'(beats), 256'(4));
    burst_resp  = 1'b0;
    burst_rdata = '0;
    check({tag, "_done_resp"},  256'(line_resp),   256'(1));
    check({tag, "_done_rdata"}, line_rdata,        exp_rdata);
    check({tag, "_done_bread"}, 256'(burst_read),  256'(0));
    check({tag, "_done_bwr"},   256'(burst_write), 256'(0));
    line_read  = 1'b0;
    line_write = 1'b0;
    @(negedge clk);
    check_quiet({tag, "_idle"});
    check({tag, "_idle_rdata"}, line_rdata, exp_rdata);
  endtask

  initial begin
    logic [255:0] rline;
    logic [255:0] wline;
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    line_read    = 1'b0;
    line_write   = 1'b0;
    line_address = '0;
    line_wdata   = '0;
    burst_rdata  = '0;
    burst_resp   = 1'b0;
    exp_line     = '0;

    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_rdata", line_rdata, 256'(0));
    rst = 1'b0;
    @(negedge clk);
    check_quiet("post_reset_idle");

    // Memory acknowledges in IDLE are ignored.
    burst_resp = 1'b1;
    @(negedge clk);
    burst_resp = 1'b0;
    check_quiet("idle_resp_ignored");

    // Read, no stalls: line_resp lands exactly four beats after burst start.
    rline = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    exp_line = rline;
    line_op("rd_nostall", 1'b1, 1'b0, 32'h0000_1234, '0, rline, 1'b0, 1'b0, 1'b1, exp_line);

    // Write with memory stalling every other cycle; line_rdata unchanged.
    wline = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    line_op("wr_stall", 1'b0, 1'b1, 32'h8000_0040, wline, '0, 1'b1, 1'b0, 1'b0, exp_line);

    // Read and write together: read wins, then the write is re-presented.
    rline = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
             64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
    exp_line = rline;
    line_op("both_rd", 1'b1, 1'b1, 32'h0000_0A00, wline, rline, 1'b0, 1'b0, 1'b1, exp_line);
    line_op("both_wr", 1'b0, 1'b1, 32'h0000_0A00, wline, '0, 1'b0, 1'b0, 1'b0, exp_line);

    // Reset after the second read beat of a burst.
    line_read    = 1'b1;
    line_address = 32'h0000_0300;
    @(negedge clk);
    burst_resp  = 1'b1;
    burst_rdata = 64'h9999_9999_9999_9999;
    @(negedge clk);
    burst_rdata = 64'h8888_8888_8888_8888;
    @(negedge clk);
    burst_resp = 1'b0;
    check("mid_rst_pre_bread", 256'(burst_read), 256'(1));
    #2 rst = 1'b1;
    #1;
    check_quiet("mid_rst_async");
    check("mid_rst_rdata", line_rdata, 256'(0));
    line_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_quiet("mid_rst_idle");
    rline = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
             64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
    exp_line = rline;
    line_op("rd_after_rst", 1'b1, 1'b0, 32'h0000_0300, '0, rline, 1'b0, 1'b0, 1'b1, exp_line);

    // Line inputs change after beat 1; latched address and data must hold.
    wline = {64'h1000_0000_0000_0004, 64'h1000_0000_0000_0003,
             64'h1000_0000_0000_0002, 64'h1000_0000_0000_0001};
    line_op("wr_perturb", 1'b0, 1'b1, 32'h0000_7770, wline, '0, 1'b0, 1'b1, 1'b0, exp_line);
    rline = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
             64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};
    exp_line = rline;
    line_op("rd_perturb", 1'b1, 1'b0, 32'h0000_5558, '0, rline, 1'b1, 1'b1, 1'b1, exp_line);

    // Back-to-back reads with the request low for one cycle in between.
    rline = {64'h0100_0000_0000_0003, 64'h0100_0000_0000_0002,
             64'h0100_0000_0000_0001, 64'h0100_0000_0000_0000};
    exp_line = rline;
    line_op("b2b_a", 1'b1, 1'b0, 32'h0000_0100, '0, rline, 1'b0, 1'b0, 1'b1, exp_line);
    rline = {64'h0200_0000_0000_0003, 64'h0200_0000_0000_0002,
             64'h0200_0000_0000_0001, 64'h0200_0000_0000_0000};
    exp_line = rline;
    line_op("b2b_b", 1'b1, 1'b0, 32'h0000_0200, '0, rline, 1'b0, 1'b0, 1'b1, exp_line);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_burst_adaptor.md
Name: line_burst_adaptor

Overview:
- Memory-side responder for the arbiter's single cacheline port (ab_pmem_*).
- Accepts one 256-bit line read or write and performs it as a 4-beat, 64-bit burst to physical memory.
- Returns the assembled line plus a one-cycle response to the requester.
- Sits between the arbiter (or L2 miss path) and the physical memory model.

Parameters:
- LINE_WIDTH, 256, cacheline width in bits.
- BEAT_WIDTH, 64, memory bus width per beat; BEATS = LINE_WIDTH/BEAT_WIDTH = 4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- line_read  in  1  line read request, held by requester until line_resp.
- line_write  in  1  line write request, held until line_resp.
- line_address  in  32  line address; bits [4:0] ignored.
- line_wdata  in  256  write line; beat i = bits [64i+63:64i].
- line_rdata  out  256  assembled read line.
- line_resp  out  1  one-cycle completion pulse.
- burst_read  out  1  memory read burst request.
- burst_write  out  1  memory write burst request.
- burst_address  out  32  {latched_addr[31:5], 5'b0}.
- burst_wdata  out  64  current write beat.
- burst_rdata  in  64  current read beat.
- burst_resp  in  1  memory beat acknowledge, one per beat.

Behaviour:
- States: IDLE, READ, WRITE, DONE. Beat counter is 2 bits.
- Reset (async, any state, including mid-burst):
  - State goes to IDLE; counter = 0; line_rdata = 0.
  - line_resp, burst_read and burst_write = 0; burst_address and burst_wdata = 0.
  - A burst in flight is abandoned and not resumed.
- IDLE:
  - On line_read or line_write, latch address and wdata and go to READ or WRITE; counter = 0.
  - Both asserted: read wins, the write is ignored until it is re-presented.
  - Otherwise remain in IDLE with all outputs low.
- READ:
  - burst_read = 1 continuously; burst_address is taken from the latch.
  - On each burst_resp, write burst_rdata into line_rdata beat[counter] and increment counter.
  - On the burst_resp with counter = 3, go to DONE; counter wraps to 0.
  - No burst_resp: hold state, no timeout.
- WRITE:
  - burst_write = 1 continuously; burst_wdata = latched wdata beat[counter].
  - Increment counter on each burst_resp; with counter = 3, go to DONE.
- DONE:
  - line_resp = 1 for exactly one cycle; line_rdata is valid in this cycle.
  - Burst signals low. Unconditionally go to IDLE.
- line_rdata holds its value until the next read burst starts overwriting beats; it is unchanged by writes.
- Latched inputs are frozen during a burst; changes to line_* mid-burst are ignored.
- Latency: request seen in IDLE at cycle T; burst_* asserted from T+1.
  - With burst_resp every cycle, beats land at T+1..T+4, line_resp at T+5.
  - Each memory stall cycle adds one cycle.
- Back-to-back: the request must drop the cycle after line_resp. A request still high in IDLE is treated as new.
- burst_resp in IDLE or DONE is ignored.

Test Plan:
- Read, no stalls: line_read, addr 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on T+1..T+4.
  - Required: burst_address 0x0000_1220 and line_resp at T+5.
  - Required: line_rdata = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write, stalls: line_write, addr 0x8000_0040, wdata beats A/B/C/D, burst_resp only on every other cycle.
  - Required: burst_wdata presents A,B,C,D, each advancing only after its resp.
  - Required: line_resp one cycle after the 4th resp; line_rdata unchanged.
- Simultaneous read and write asserted: required read burst only (burst_write never high); write serviced after re-presenting.
- Reset mid-burst: assert rst after the 2nd read beat.
  - Required: all outputs 0 immediately (async); state IDLE.
  - Required: a fresh read afterwards completes with correct 4-beat data.
- Input change mid-burst: change line_address and line_wdata after beat 1.
  - Required: burst_address and remaining beats use the values latched at accept.
- Back-to-back reads to 0x100 then 0x200, with the request dropped for one cycle between: required two independent bursts, two single-cycle line_resp pulses, correct data each.
